// File: rtl/regfile_pkg.sv
// Shared constants and types for the 8x8 general-purpose register file.
// Register 0 is the hardwired zero register on every port.
package regfile_pkg;

  localparam int RF_DATA_W   = 8;
  localparam int RF_ADDR_W   = 3;
  localparam int RF_DEPTH    = 1 << RF_ADDR_W;
  localparam int RF_ZERO_REG = 0;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: register mux, zero-register masking and an
// optional write-through compare against the port being written this cycle.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH   = RF_DATA_W,
  parameter int ADDR_WIDTH   = RF_ADDR_W,
  parameter int WRITE_BYPASS = 0
) (
  input  logic [ADDR_WIDTH-1:0]                       i_addr,
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]  i_regs,
  input  logic                                        i_rst,
  input  logic                                        i_wr,
  input  logic [ADDR_WIDTH-1:0]                       i_wr_addr,
  input  logic [DATA_WIDTH-1:0]                       i_wr_data,
  output logic [DATA_WIDTH-1:0]                       o_data
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(RF_ZERO_REG);

  logic w_is_zero;
  logic w_bypass_hit;

  assign w_is_zero = (i_addr == ZERO_ADDR);

  // Write-through only for a real write to a real register; the compare folds away when disabled.
  assign w_bypass_hit = (WRITE_BYPASS != 0) && i_wr && !i_rst &&
                        (i_wr_addr != ZERO_ADDR) && (i_addr == i_wr_addr);

  always_comb begin
    if (w_is_zero) begin
      o_data = '0;
    end else if (w_bypass_hit) begin
      o_data = i_wr_data;
    end else begin
      o_data = i_regs[i_addr];
    end
  end

endmodule

// File: rtl/regfile_8x8.sv
// 8x8 register file: two combinational read ports, one synchronous write port,
// R0 hardwired to zero. Storage and write logic live here; reads in regfile_read_port.
module regfile_8x8
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH   = RF_DATA_W,
  parameter int ADDR_WIDTH   = RF_ADDR_W,
  parameter int WRITE_BYPASS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] AA,
  input  logic [ADDR_WIDTH-1:0] BA,
  input  logic [ADDR_WIDTH-1:0] DA,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  WR,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]                r_regs [DEPTH-1:1];
  logic [DEPTH-1:0][DATA_WIDTH-1:0]     w_regs;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (WR) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (DA == i[ADDR_WIDTH-1:0]) begin
          r_regs[i] <= data_in;
        end
      end
    end
  end

  // Slot 0 is a constant so the zero register never carries X.
  always_comb begin
    w_regs[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      w_regs[i] = r_regs[i];
    end
  end

  regfile_read_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WRITE_BYPASS(WRITE_BYPASS)
  ) u_port_a (
    .i_addr   (AA),
    .i_regs   (w_regs),
    .i_rst    (rst),
    .i_wr     (WR),
    .i_wr_addr(DA),
    .i_wr_data(data_in),
    .o_data   (data_a)
  );

  regfile_read_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WRITE_BYPASS(WRITE_BYPASS)
  ) u_port_b (
    .i_addr   (BA),
    .i_regs   (w_regs),
    .i_rst    (rst),
    .i_wr     (WR),
    .i_wr_addr(DA),
    .i_wr_data(data_in),
    .o_data   (data_b)
  );

endmodule

// File: tb/tb_regfile_8x8.sv
// Bench for regfile_8x8: both bypass builds driven in parallel and checked
// against an array-based reference model of the register file.
module tb_regfile_8x8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] AA = '0, BA = '0, DA = '0;
  logic [7:0] data_in = '0;
  logic       WR = 1'b0;
  logic [7:0] a0, b0, a1, b1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mdl [8];

  always #5 clk = ~clk;

  regfile_8x8 #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .WRITE_BYPASS(0)) u_dut0 (
    .clk(clk), .rst(rst), .AA(AA), .BA(BA), .DA(DA),
    .data_in(data_in), .WR(WR), .data_a(a0), .data_b(b0)
  );

  regfile_8x8 #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .WRITE_BYPASS(1)) u_dut1 (
    .clk(clk), .rst(rst), .AA(AA), .BA(BA), .DA(DA),
    .data_in(data_in), .WR(WR), .data_a(a1), .data_b(b1)
  );

  // Reference read: R0 is zero, bypass build forwards a live write to a nonzero address.
  function automatic logic [7:0] exp_rd(input logic [2:0] addr, input bit byp);
    if (addr == 3'd0) return 8'h00;
    if (byp && WR && !rst && DA != 3'd0 && addr == DA) return data_in;
    return mdl[addr];
  endfunction

  // Apply inputs after a falling edge and let them settle well before the rising edge.
  task automatic drive(input logic r, input logic w, input logic [2:0] d,
                       input logic [7:0] din, input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    rst = r; WR = w; DA = d; data_in = din; AA = a; BA = b;
    #1;
  endtask

  // Rising edge with the model updated by the same rules the hardware follows.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    end else if (WR && DA != 3'd0) begin
      mdl[DA] = data_in;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 1'b1, i[2:0], 8'($urandom), 3'd0, 3'd0);
      tick();
    end
    drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 3'd0, 8'h00, i[2:0], i[2:0]);
      n_cmp += 4;
      if (a0 !== 8'h00 || b0 !== 8'h00 || a1 !== 8'h00 || b1 !== 8'h00) begin
        n_bad++;
        $display("FAIL reset addr=%0d got a0=%h b0=%h a1=%h b1=%h want 00", i, a0, b0, a1, b1);
      end
    end
  endtask

  task automatic test_basic();
    drive(1'b0, 1'b1, 3'd1, 8'h05, 3'd0, 3'd0); tick();
    drive(1'b0, 1'b1, 3'd2, 8'h0A, 3'd0, 3'd0); tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd2);
    n_cmp += 2;
    if (a0 !== 8'h05 || a1 !== 8'h05) begin
      n_bad++; $display("FAIL basic_a got %h/%h want 05", a0, a1);
    end
    if (b0 !== 8'h0A || b1 !== 8'h0A) begin
      n_bad++; $display("FAIL basic_b got %h/%h want 0a", b0, b1);
    end
  endtask

  task automatic test_overwrite();
    drive(1'b0, 1'b1, 3'd1, 8'h01, 3'd0, 3'd0); tick();
    drive(1'b0, 1'b1, 3'd2, 8'h02, 3'd0, 3'd0); tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd2);
    n_cmp += 2;
    if (a0 !== 8'h01 || a1 !== 8'h01) begin
      n_bad++; $display("FAIL overwrite_a got %h/%h want 01", a0, a1);
    end
    if (b0 !== 8'h02 || b1 !== 8'h02) begin
      n_bad++; $display("FAIL overwrite_b got %h/%h want 02", b0, b1);
    end
  endtask

  task automatic test_zero_reg();
    drive(1'b0, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd0);
    n_cmp++;
    if (a1 !== 8'h00 || a0 !== 8'h00) begin
      n_bad++; $display("FAIL zero_bypass got a0=%h a1=%h want 00", a0, a1);
    end
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    n_cmp++;
    if (a0 !== 8'h00 || b0 !== 8'h00 || a1 !== 8'h00 || b1 !== 8'h00) begin
      n_bad++; $display("FAIL zero_read got %h %h %h %h want 00", a0, b0, a1, b1);
    end
  endtask

  task automatic test_reset_priority();
    drive(1'b0, 1'b1, 3'd3, 8'h77, 3'd0, 3'd0); tick();
    drive(1'b1, 1'b1, 3'd3, 8'h55, 3'd3, 3'd3);
    n_cmp++;
    if (a1 !== 8'h77) begin
      n_bad++; $display("FAIL rst_no_bypass got a1=%h want 77", a1);
    end
    tick();
    drive(1'b0, 1'b0, 3'd3, 8'hAA, 3'd3, 3'd3);
    n_cmp++;
    if (a0 !== 8'h00 || a1 !== 8'h00) begin
      n_bad++; $display("FAIL rst_priority got %h/%h want 00", a0, a1);
    end
    tick();
    n_cmp++;
    if (a0 !== 8'h00 || b1 !== 8'h00) begin
      n_bad++; $display("FAIL wr_disable got %h/%h want 00", a0, b1);
    end
  endtask

  task automatic test_hazard();
    drive(1'b0, 1'b1, 3'd4, 8'h11, 3'd0, 3'd0); tick();
    drive(1'b0, 1'b1, 3'd4, 8'h22, 3'd4, 3'd4);
    n_cmp += 2;
    if (a0 !== 8'h11) begin
      n_bad++; $display("FAIL hazard_nobyp got %h want 11", a0);
    end
    if (a1 !== 8'h22 || b1 !== 8'h22) begin
      n_bad++; $display("FAIL hazard_byp got %h/%h want 22", a1, b1);
    end
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd4);
    n_cmp++;
    if (a0 !== 8'h22 || a1 !== 8'h22) begin
      n_bad++; $display("FAIL hazard_after got %h/%h want 22", a0, a1);
    end
  endtask

  task automatic test_random();
    logic [7:0] e0a, e0b, e1a, e1b;
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 31) == 0), 1'($urandom), 3'($urandom), 8'($urandom),
            3'($urandom), 3'($urandom));
      e0a = exp_rd(AA, 1'b0); e0b = exp_rd(BA, 1'b0);
      e1a = exp_rd(AA, 1'b1); e1b = exp_rd(BA, 1'b1);
      n_cmp += 4;
      if (a0 !== e0a) begin n_bad++; $display("FAIL rand_a0 n=%0d got %h want %h", n, a0, e0a); end
      if (b0 !== e0b) begin n_bad++; $display("FAIL rand_b0 n=%0d got %h want %h", n, b0, e0b); end
      if (a1 !== e1a) begin n_bad++; $display("FAIL rand_a1 n=%0d got %h want %h", n, a1, e1a); end
      if (b1 !== e1b) begin n_bad++; $display("FAIL rand_b1 n=%0d got %h want %h", n, b1, e1b); end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    tick();
    test_reset();
    test_basic();
    test_overwrite();
    test_zero_reg();
    test_reset_priority();
    test_hazard();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_8x8.md
Name: regfile_8x8

Overview:
- Multi-ported general-purpose register file for the pipelined CPU core: 8 registers × 8 bits.
- Two independent combinational read ports (A, B) and one synchronous write port (D).
- Register 0 is hardwired to zero.
- Sits in the decode/register-read stage; the writeback stage drives the write port.

Parameters:
- DATA_WIDTH, 8, bit width of each register and of all data ports.
- ADDR_WIDTH, 3, address width; register count = 2**ADDR_WIDTH (8).
- WRITE_BYPASS, 0, when 1 a read of the address being written in the same cycle returns data_in (write-through); when 0 it returns the stored (old) value until the clock edge.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- AA  input  ADDR_WIDTH  read port A address.
- BA  input  ADDR_WIDTH  read port B address.
- DA  input  ADDR_WIDTH  write (destination) address.
- data_in  input  DATA_WIDTH  write data.
- WR  input  1  write enable, active high.
- data_a  output  DATA_WIDTH  contents of register AA.
- data_b  output  DATA_WIDTH  contents of register BA.

Behaviour:
- Storage: R1..R7 are flops, DATA_WIDTH each. R0 has no storage and always reads 0.
- Reset:
  - Synchronous, active-high.
  - On a rising clk with rst=1, R1..R7 are cleared to 0.
  - rst has priority over WR.
  - Outputs follow combinationally, so after the reset edge data_a = data_b = 0 for every address.
- Write:
  - On a rising clk with rst=0 and WR=1, R[DA] <= data_in.
  - Writes with DA=0 are discarded; R0 stays 0.
  - WR=0 leaves all registers unchanged.
- Read:
  - Purely combinational (zero-cycle latency): data_a = R[AA], data_b = R[BA].
  - AA=0 or BA=0 yields 0.
  - AA = BA is legal; both ports return the same value.
- Write latency: a written value is visible on the read ports immediately after the capturing edge, i.e. one cycle after presentation when WRITE_BYPASS=0.
- Same-cycle read/write of the same address:
  - WRITE_BYPASS=0: the old value is returned before the edge.
  - WRITE_BYPASS=1: data_in is returned combinationally whenever WR=1, rst=0, DA≠0 and the read address equals DA.
  - Bypass is never applied for DA=0 or while rst=1.
- X-safety: no X propagates from R0. All addresses are in range by construction, so there is no out-of-range case.

Decomposition:
- Shared package regfile_pkg:
  - constants RF_DATA_W=8, RF_ADDR_W=3, RF_DEPTH=8;
  - typedefs rf_addr_t and rf_data_t;
  - localparam RF_ZERO_REG=0.
- One natural sub-module: regfile_read_port.
  - Mux plus zero-register masking plus optional bypass compare.
  - Instantiated twice (port A, port B) by regfile_8x8.
  - Storage and write logic stay in the top module.

Test Plan:
- Reset: apply rst=1 for one edge after arbitrary prior writes, then sweep AA=BA=0..7 -> data_a=data_b=0x00 at every address.
- Basic write/read: WR=1, write DA=1 data_in=0x05, next edge DA=2 data_in=0x0A; then WR=0, AA=1, BA=2 -> data_a=0x05, data_b=0x0A.
- Overwrite: WR=1, write R1=0x01 then R2=0x02; WR=0, AA=1, BA=2 -> data_a=0x01, data_b=0x02 (old values replaced).
- Zero register: WR=1, DA=0, data_in=0xFF for one edge; WR=0, AA=BA=0 -> data_a=data_b=0x00. Also WR=1 with WRITE_BYPASS=1, AA=0, DA=0 -> data_a=0x00.
- Reset priority and write-disable: rst=1 with WR=1, DA=3, data_in=0x55 -> R3 reads 0x00. Then rst=0, WR=0, DA=3, data_in=0xAA -> R3 still 0x00.
- Same-cycle hazard: R4=0x11 stored; present WR=1, DA=4, data_in=0x22, AA=4 -> before the edge data_a=0x11 (WRITE_BYPASS=0) or 0x22 (WRITE_BYPASS=1); after the edge data_a=0x22 in both builds.
